i2s_rx: RTL and testbench

//  I2S receiver: deserialises 24-bit stereo samples from an external codec's Din/SCLK/LRCLK

---
 rtl/i2s_rx.sv | 234 +++++++++++++++++++++++
 tb/tb_i2s_rx.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx.sv
// i2s_rx: oversampled I2S receiver, captures WORD_W-bit stereo pairs into a small FIFO.
// Optional peak meters (peak_left/peak_right/peak_clr) are built when I2S_RX_PEAK_EN is defined.
//   state    | meaning
//   ALIGN    | waiting for LRCLK fall (start of a left word)
//   SKIP     | ignoring the one-bit I2S delay slot
//   SHIFT    | capturing data bits MSB first
//   DONE     | word committed, ignoring slot padding until next LRCLK edge
module i2s_rx #(
    parameter int FIFO_DEPTH = 4,
    parameter int WORD_W     = 24
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          SCLK,
    input  logic                          LRCLK,
    input  logic                          Din,
    input  logic                          enable,
    output logic [WORD_W-1:0]             sample_left,
    output logic [WORD_W-1:0]             sample_right,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    input  logic                          overrun_clr
`ifdef I2S_RX_PEAK_EN
    ,
    output logic [WORD_W-2:0]             peak_left,
    output logic [WORD_W-2:0]             peak_right,
    input  logic                          peak_clr
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WORD_W - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_ALIGN = 2'd0;
    localparam logic [1:0] ST_SKIP  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [2:0]              sclk_sync_q, sclk_sync_d;
    logic [2:0]              lr_sync_q, lr_sync_d;
    logic [1:0]              din_sync_q, din_sync_d;
    logic [1:0]              state_q, state_d;
    logic                    chan_q, chan_d;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]       shift_q, shift_d;
    logic [WORD_W-1:0]       left_hold_q, left_hold_d;
    logic [2*WORD_W-1:0]     mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [WORD_W-1:0]       out_left_q, out_left_d, out_right_q, out_right_d;
    logic                    overrun_q, overrun_d;

    logic                    sclk_rise, lr_edge, lr_fall, lr_now, din_bit;
    logic                    commit, push_req, push, pop, drop;
    logic [WORD_W-1:0]       commit_word, shift_bit;
    logic [2*WORD_W-1:0]     push_data;

    // Din is taken from the same synchroniser depth as the SCLK edge it belongs to.
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign lr_now    = lr_sync_q[1];
    assign lr_edge   = lr_sync_q[1] ^ lr_sync_q[2];
    assign lr_fall   = lr_edge & ~lr_now;
    assign din_bit   = din_sync_q[1];

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], SCLK};
        lr_sync_d   = {lr_sync_q[1:0], LRCLK};
        din_sync_d  = {din_sync_q[0], Din};
        state_d     = state_q;
        chan_d      = chan_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        commit      = 1'b0;
        commit_word = shift_q;
        shift_bit   = shift_q;
        shift_bit[CNT_MAX - bit_cnt_q] = din_bit;

        if (!enable) begin
            state_d = ST_ALIGN;
        end else begin
            case (state_q)
                ST_ALIGN: begin
                    if (lr_fall) begin
                        state_d = ST_SKIP;
                        chan_d  = 1'b0;
                        shift_d = '0;
                    end
                end
                ST_SKIP: begin
                    if (lr_edge) begin
                        state_d = ST_ALIGN;
                    end else if (sclk_rise) begin
                        state_d   = ST_SHIFT;
                        bit_cnt_d = '0;
                    end
                end
                ST_SHIFT: begin
                    // Early LRCLK edge: short slot, keep what arrived left-justified.
                    if (lr_edge) begin
                        commit  = 1'b1;
                        state_d = ST_SKIP;
                        chan_d  = lr_now;
                        shift_d = '0;
                    end else if (sclk_rise) begin
                        shift_d   = shift_bit;
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_MAX) begin
                            commit      = 1'b1;
                            commit_word = shift_bit;
                            state_d     = ST_DONE;
                        end
                    end
                end
                default: begin
                    if (lr_edge) begin
                        state_d = ST_SKIP;
                        chan_d  = lr_now;
                        shift_d = '0;
                    end
                end
            endcase
        end

        left_hold_d = (commit && !chan_q) ? commit_word : left_hold_q;
        push_req    = commit & chan_q;
        push_data   = {left_hold_q, commit_word};
    end

    always_comb begin
        pop       = (level_q != '0) && sample_ready;
        drop      = push_req && (level_q == LVL_FULL);
        push      = push_req && !drop;
        wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d   = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - LVL_W'(1);
        end
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        // Head register: bypass a push landing on the new head slot, otherwise read memory.
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            {out_left_d, out_right_d} = push_data;
        end else if (pop && (level_q > LVL_W'(1))) begin
            {out_left_d, out_right_d} = mem_q[rd_ptr_d];
        end
        overrun_d = overrun_q;
        if (overrun_clr) overrun_d = 1'b0;
        if (drop)        overrun_d = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sclk_sync_q <= '0;
            lr_sync_q   <= '0;
            din_sync_q  <= '0;
            state_q     <= ST_ALIGN;
            chan_q      <= 1'b0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            left_hold_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            out_left_q  <= '0;
            out_right_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            lr_sync_q   <= lr_sync_d;
            din_sync_q  <= din_sync_d;
            state_q     <= state_d;
            chan_q      <= chan_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            left_hold_q <= left_hold_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            overrun_q   <= overrun_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign sample_left  = out_left_q;
    assign sample_right = out_right_q;
    assign sample_valid = (level_q != '0);
    assign fifo_level   = level_q;
    assign overrun      = overrun_q;

`ifdef I2S_RX_PEAK_EN
    logic [WORD_W-2:0] peak_left_q, peak_left_d, peak_right_q, peak_right_d, commit_mag;
    logic [WORD_W-1:0] commit_abs;

    always_comb begin
        commit_abs   = commit_word[WORD_W-1] ? -commit_word : commit_word;
        // Only the most negative code still has its MSB set after negation; clamp it.
        commit_mag   = commit_abs[WORD_W-1] ? '1 : commit_abs[WORD_W-2:0];
        peak_left_d  = peak_left_q;
        peak_right_d = peak_right_q;
        if (peak_clr) begin
            peak_left_d  = (commit && !chan_q) ? commit_mag : '0;
            peak_right_d = (commit && chan_q) ? commit_mag : '0;
        end else begin
            if (commit && !chan_q && (commit_mag > peak_left_q))  peak_left_d  = commit_mag;
            if (commit && chan_q && (commit_mag > peak_right_q))  peak_right_d = commit_mag;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            peak_left_q  <= '0;
            peak_right_q <= '0;
        end else begin
            peak_left_q  <= peak_left_d;
            peak_right_q <= peak_right_d;
        end
    end

    assign peak_left  = peak_left_q;
    assign peak_right = peak_right_q;
`endif
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: drives I2S frames into i2s_rx and checks popped pairs against a frame-level model.
module tb_i2s_rx;
    localparam int WORD_W     = 24;
    localparam int FIFO_DEPTH = 4;
    localparam int HALF       = 4;

    logic CLK = 1'b0;
    logic RESET, SCLK, LRCLK, Din, enable, sample_ready, overrun_clr;
    logic [WORD_W-1:0] sample_left, sample_right;
    logic              sample_valid, overrun;
    logic [2:0]        fifo_level;
`ifdef I2S_RX_PEAK_EN
    logic [WORD_W-2:0] peak_left, peak_right;
    logic              peak_clr;
`endif

    int checks = 0;
    int errors = 0;
    logic [2*WORD_W-1:0] got_q[$];
    logic [2*WORD_W-1:0] model_q[$];

    i2s_rx #(.FIFO_DEPTH(FIFO_DEPTH), .WORD_W(WORD_W)) dut (
        .CLK(CLK), .RESET(RESET), .SCLK(SCLK), .LRCLK(LRCLK), .Din(Din), .enable(enable),
        .sample_left(sample_left), .sample_right(sample_right), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .fifo_level(fifo_level), .overrun(overrun),
        .overrun_clr(overrun_clr)
`ifdef I2S_RX_PEAK_EN
        , .peak_left(peak_left), .peak_right(peak_right), .peak_clr(peak_clr)
`endif
    );

    always #10 CLK = ~CLK;

    // Record every pair the DUT hands over (valid & ready seen before the popping edge).
    always begin
        @(negedge CLK);
        #1;
        if (!RESET && sample_valid && sample_ready) got_q.push_back({sample_left, sample_right});
    end

    task automatic clk_n(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // abort: 0 none, 1 RESET pulse, 2 enable low, applied during this bit's low phase
    task automatic send_bit(input logic lr, input logic d, input int abort, input bit lat_chk);
        SCLK = 1'b0; LRCLK = lr; Din = d;
        clk_n(HALF);
        if (abort == 1) begin RESET = 1'b1; clk_n(10); RESET = 1'b0; end
        if (abort == 2) begin enable = 1'b0; clk_n(10); enable = 1'b1; end
        SCLK = 1'b1;
        if (lat_chk) begin
            repeat (5) @(posedge CLK);
            #1;
            checks++;
            if (sample_valid !== 1'b1) begin
                errors++; $display("FAIL latency valid got %b want 1", sample_valid);
            end
            @(negedge CLK);
        end else begin
            clk_n(HALF);
        end
    endtask

    // Frame model: a slot of len SCLKs carries a delay bit then min(len-1, WORD_W) bits MSB first.
    task automatic send_frame(input logic [WORD_W-1:0] l, input logic [WORD_W-1:0] r,
                              input int l_len, input int r_len, input int abort_mode,
                              input int abort_bit, input bit lat_chk,
                              output logic [WORD_W-1:0] exp_l, output logic [WORD_W-1:0] exp_r);
        logic [WORD_W-1:0] w, keep;
        logic d;
        int len, ncap;
        for (int ch = 0; ch < 2; ch++) begin
            w    = (ch == 1) ? r : l;
            len  = (ch == 1) ? r_len : l_len;
            ncap = (len - 1 < WORD_W) ? len - 1 : WORD_W;
            for (int k = 0; k < len; k++) begin
                d = (k >= 1 && k <= ncap) ? w[WORD_W-k] : 1'($urandom);
                send_bit(ch[0], d, (ch == 1 && k == abort_bit) ? abort_mode : 0,
                         lat_chk && ch == 1 && k == ncap);
            end
            keep = '1;
            keep = keep << (WORD_W - ncap);
            if (ch == 1) exp_r = w & keep; else exp_l = w & keep;
        end
    endtask

    task automatic pop_one();
        sample_ready = 1'b1;
        clk_n(1);
        sample_ready = 1'b0;
        clk_n(1);
    endtask

    task automatic test_reset();
        clk_n(3);
        checks++;
        if ({sample_valid, fifo_level, overrun, sample_left, sample_right} !== '0) begin
            errors++; $display("FAIL reset_outputs got v=%b lvl=%0d ovr=%b l=%h r=%h want all 0",
                               sample_valid, fifo_level, overrun, sample_left, sample_right);
        end
        RESET = 1'b0; enable = 1'b1;
        clk_n(20);
        checks++;
        if (sample_valid !== 1'b0 || fifo_level !== 3'd0) begin
            errors++; $display("FAIL reset_idle got v=%b lvl=%0d want 0 0", sample_valid, fifo_level);
        end
    endtask

    task automatic test_basic();
        logic [WORD_W-1:0] el, er;
        logic [2*WORD_W-1:0] g;
        got_q.delete();
        send_frame(24'h123456, 24'hABCDEF, 32, 32, 0, -1, 1'b1, el, er);
        clk_n(2);
        checks++;
        if (fifo_level !== 3'd1 || sample_left !== 24'h123456 || sample_right !== 24'hABCDEF) begin
            errors++; $display("FAIL basic_head got lvl=%0d l=%h r=%h want 1 123456 abcdef",
                               fifo_level, sample_left, sample_right);
        end
        pop_one();
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL basic_pop got %0d pairs want 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            if (g !== {el, er}) begin
                errors++; $display("FAIL basic_pop got %h want %h", g, {el, er});
            end
        end
        checks++;
        if (fifo_level !== 3'd0 || sample_valid !== 1'b0) begin
            errors++; $display("FAIL basic_empty got lvl=%0d v=%b want 0 0", fifo_level, sample_valid);
        end
    endtask

    task automatic test_overrun();
        logic [WORD_W-1:0] el, er;
        logic [2*WORD_W-1:0] g, e;
        bit exp_ovr = 1'b0;
        got_q.delete(); model_q.delete();
        for (int i = 0; i < 5; i++) begin
            send_frame(WORD_W'($urandom), WORD_W'($urandom), 32, 32, 0, -1, 1'b0, el, er);
            if (model_q.size() < FIFO_DEPTH) model_q.push_back({el, er}); else exp_ovr = 1'b1;
        end
        clk_n(2);
        checks++;
        if (fifo_level !== 3'(model_q.size()) || overrun !== exp_ovr) begin
            errors++; $display("FAIL ovr_full got lvl=%0d ovr=%b want %0d %b",
                               fifo_level, overrun, model_q.size(), exp_ovr);
        end
        checks++;
        if ({sample_left, sample_right} !== model_q[0]) begin
            errors++; $display("FAIL ovr_head_hold got %h want %h", {sample_left, sample_right}, model_q[0]);
        end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            pop_one();
            e = model_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL ovr_pop%0d got nothing want %h", i, e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin errors++; $display("FAIL ovr_pop%0d got %h want %h", i, g, e); end
            end
        end
        checks++;
        if (sample_valid !== 1'b0 || fifo_level !== 3'd0 || overrun !== 1'b1 || got_q.size() != 0) begin
            errors++; $display("FAIL ovr_drained got v=%b lvl=%0d ovr=%b extra=%0d want 0 0 1 0",
                               sample_valid, fifo_level, overrun, got_q.size());
        end
        overrun_clr = 1'b1; clk_n(1); overrun_clr = 1'b0; clk_n(1);
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %b want 0", overrun); end
    endtask

    task automatic test_short_slot();
        logic [WORD_W-1:0] el, er;
        logic [2*WORD_W-1:0] g;
        int len;
        got_q.delete();
        send_frame(24'h800100, WORD_W'($urandom), 17, 32, 0, -1, 1'b0, el, er);
        pop_one();
        checks++;
        if (got_q.size() == 0) begin
            errors++; $display("FAIL short16 got nothing want left 800100");
        end else begin
            g = got_q.pop_front();
            if (g !== {24'h800100, er}) begin
                errors++; $display("FAIL short16 got %h want %h", g, {24'h800100, er});
            end
        end
        for (int i = 0; i < 3; i++) begin
            len = $urandom_range(25, 3);
            send_frame(WORD_W'($urandom), WORD_W'($urandom), len, 32, 0, -1, 1'b0, el, er);
            pop_one();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL short_rand len=%0d got nothing want %h", len, {el, er});
            end else begin
                g = got_q.pop_front();
                if (g !== {el, er}) begin
                    errors++; $display("FAIL short_rand len=%0d got %h want %h", len, g, {el, er});
                end
            end
        end
    endtask

    task automatic test_abort(input int mode);
        logic [WORD_W-1:0] al, ar, el, er;
        logic [2*WORD_W-1:0] g;
        int exp_lvl;
        got_q.delete(); model_q.delete();
        send_frame(WORD_W'($urandom), WORD_W'($urandom), 32, 32, 0, -1, 1'b0, al, ar);
        if (mode == 2) model_q.push_back({al, ar});
        send_frame(WORD_W'($urandom), WORD_W'($urandom), 32, 32, mode, 10, 1'b0, el, er);
        exp_lvl = model_q.size();
        checks++;
        if (fifo_level !== 3'(exp_lvl) || sample_valid !== (exp_lvl != 0)) begin
            errors++; $display("FAIL abort%0d_level got lvl=%0d v=%b want %0d", mode, fifo_level,
                               sample_valid, exp_lvl);
        end
        send_frame(WORD_W'($urandom), WORD_W'($urandom), 32, 32, 0, -1, 1'b0, el, er);
        model_q.push_back({el, er});
        while (model_q.size() > 0) begin
            pop_one();
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL abort%0d_pop got nothing want %h", mode, model_q[0]);
                void'(model_q.pop_front());
            end else begin
                g = got_q.pop_front();
                if (g !== model_q[0]) begin
                    errors++; $display("FAIL abort%0d_pop got %h want %h", mode, g, model_q[0]);
                end
                void'(model_q.pop_front());
            end
        end
        checks++;
        if (fifo_level !== 3'd0 || got_q.size() != 0) begin
            errors++; $display("FAIL abort%0d_drain got lvl=%0d extra=%0d want 0 0", mode,
                               fifo_level, got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [WORD_W-1:0] el, er;
        logic [2*WORD_W-1:0] g;
        got_q.delete(); model_q.delete();
        sample_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_frame(WORD_W'($urandom), WORD_W'($urandom), 32, 32, 0, -1, 1'b0, el, er);
            model_q.push_back({el, er});
        end
        clk_n(10);
        sample_ready = 1'b0;
        clk_n(1);
        checks++;
        if (got_q.size() != model_q.size() || overrun !== 1'b0 || fifo_level !== 3'd0) begin
            errors++; $display("FAIL stream_count got n=%0d ovr=%b lvl=%0d want %0d 0 0",
                               got_q.size(), overrun, fifo_level, model_q.size());
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (got_q.size() == 0) begin
                errors++; $display("FAIL stream%0d got nothing want %h", i, model_q[i]);
            end else begin
                g = got_q.pop_front();
                if (g !== model_q[i]) begin
                    errors++; $display("FAIL stream%0d got %h want %h", i, g, model_q[i]);
                end
            end
        end
    endtask

`ifdef I2S_RX_PEAK_EN
    function automatic logic [WORD_W-2:0] mag_of(input logic [WORD_W-1:0] w);
        int v;
        v = int'($signed(w));
        if (v < 0) v = -v;
        if (v > (1 << (WORD_W - 1)) - 1) v = (1 << (WORD_W - 1)) - 1;
        return v[WORD_W-2:0];
    endfunction

    task automatic test_peak();
        logic [WORD_W-1:0] lw [3];
        logic [WORD_W-1:0] el, er;
        logic [WORD_W-2:0] exp_l = '0, exp_r = '0;
        lw[0] = 24'h000100; lw[1] = 24'hFFF000; lw[2] = 24'h000010;
        peak_clr = 1'b1; clk_n(1); peak_clr = 1'b0; clk_n(1);
        for (int i = 0; i < 3; i++) begin
            send_frame(lw[i], WORD_W'($urandom), 32, 32, 0, -1, 1'b0, el, er);
            if (mag_of(el) > exp_l) exp_l = mag_of(el);
            if (mag_of(er) > exp_r) exp_r = mag_of(er);
        end
        clk_n(2);
        checks++;
        if (peak_left !== exp_l || peak_right !== exp_r) begin
            errors++; $display("FAIL peak_hold got l=%h r=%h want %h %h", peak_left, peak_right,
                               exp_l, exp_r);
        end
        peak_clr = 1'b1; clk_n(1); peak_clr = 1'b0; clk_n(1);
        checks++;
        if (peak_left !== '0 || peak_right !== '0) begin
            errors++; $display("FAIL peak_clr got l=%h r=%h want 0 0", peak_left, peak_right);
        end
        for (int i = 0; i < 3; i++) pop_one();
        got_q.delete();
    endtask
`endif

    initial begin
        RESET = 1'b1; SCLK = 1'b1; LRCLK = 1'b1; Din = 1'b0; enable = 1'b0;
        sample_ready = 1'b0; overrun_clr = 1'b0;
`ifdef I2S_RX_PEAK_EN
        peak_clr = 1'b0;
`endif
        test_reset();
        test_basic();
        test_overrun();
        test_short_slot();
        test_abort(1);
        test_abort(2);
        test_back_to_back();
`ifdef I2S_RX_PEAK_EN
        test_peak();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
